// File: rtl/tff_pkg.sv
// Shared definitions for the toggle-flop counter controller.
package tff_pkg;

  localparam int TFF_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop with synchronous clear; flips its state whenever t is high.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= q ^ t;
  end

endmodule

// File: rtl/tff_count_ctrl.sv
// Up/down counter built from a bank of toggle flops; the controller only decides
// which bits toggle each cycle (load, count, wrap, hold) from a small IDLE/RUN/DONE FSM.
module tff_count_ctrl
  import tff_pkg::*;
#(
  parameter int WIDTH = TFF_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             cont,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_e             r_state;
  state_e             w_stateNext;
  logic               r_capUp;
  logic               r_capCont;
  logic [WIDTH-1:0]   r_capMod;
  logic [WIDTH-1:0]   w_count;
  logic [WIDTH-1:0]   w_toggle;
  logic [WIDTH-1:0]   w_incToggle;
  logic [WIDTH-1:0]   w_decToggle;
  logic               w_terminal;

  // Ripple toggle chains: bit i toggles when all lower bits are 1 (up) or all 0 (down).
  always_comb begin : toggleChain
    logic upAll;
    logic dnAll;
    w_incToggle = '0;
    w_decToggle = '0;
    upAll       = 1'b1;
    dnAll       = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_incToggle[i] = upAll;
      w_decToggle[i] = dnAll;
      upAll          = upAll & w_count[i];
      dnAll          = dnAll & ~w_count[i];
    end
  end

  assign w_terminal = r_capUp ? (w_count == r_capMod) : (w_count == '0);

  always_comb begin
    w_stateNext = r_state;
    w_toggle    = '0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_toggle    = w_count ^ (up_dn ? '0 : mod_val);
          w_stateNext = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          w_stateNext = IDLE;
        end else if (w_terminal) begin
          // At terminal count is either mod_val (up) or 0 (down), so these toggles wrap it.
          if (r_capCont) w_toggle = r_capUp ? w_count : r_capMod;
          else           w_stateNext = DONE;
        end else begin
          w_toggle = r_capUp ? w_incToggle : w_decToggle;
        end
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_capUp   <= 1'b0;
      r_capCont <= 1'b0;
      r_capMod  <= '0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == IDLE && start) begin
        r_capUp   <= up_dn;
        r_capCont <= cont;
        r_capMod  <= mod_val;
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (w_toggle[g]),
      .q   (w_count[g])
    );
  end

  assign count = w_count;
  assign tc    = (r_state == RUN) && w_terminal;
  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed scoreboard bench for tff_count_ctrl at WIDTH = 4: each step pushes the
// expected post-edge outputs, clocks once, then pops and checks them.
module tb_tff_count_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       upDn;
  logic       cont;
  logic [3:0] modVal;
  logic [3:0] count;
  logic       tc;
  logic       busy;
  logic       done;

  typedef struct {
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       done;
    string      tag;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  tff_count_ctrl #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .up_dn   (upDn),
    .cont    (cont),
    .mod_val (modVal),
    .count   (count),
    .tc      (tc),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries, expected 1");
      return;
    end
    e = expQ.pop_front();
    assert (count === e.count) else begin
      errors++;
      $error("[TB] FAIL %s count: observed %0d expected %0d", e.tag, count, e.count);
    end
    checks++;
    assert (tc === e.tc) else begin
      errors++;
      $error("[TB] FAIL %s tc: observed %b expected %b", e.tag, tc, e.tc);
    end
    checks++;
    assert (busy === e.busy) else begin
      errors++;
      $error("[TB] FAIL %s busy: observed %b expected %b", e.tag, busy, e.busy);
    end
    checks++;
    assert (done === e.done) else begin
      errors++;
      $error("[TB] FAIL %s done: observed %b expected %b", e.tag, done, e.done);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic p,
                               input logic u, input logic c, input logic [3:0] m,
                               input logic [3:0] eCount, input logic eTc,
                               input logic eBusy, input logic eDone, input string tag);
    exp_t e;
    rst    = r;
    start  = s;
    stop   = p;
    upDn   = u;
    cont   = c;
    modVal = m;
    e = '{count: eCount, tc: eTc, busy: eBusy, done: eDone, tag: tag};
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [3:0] c;
    rst = 1'b1; start = 1'b0; stop = 1'b0; upDn = 1'b0; cont = 1'b0; modVal = 4'd0;

    applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, "reset");
    applyStimulus(0, 0, 1, 0, 0, 4'd9, 4'd0, 0, 0, 0, "stop_in_idle");

    // Up, one-shot to 5
    applyStimulus(0, 1, 0, 1, 0, 4'd5, 4'd0, 0, 1, 0, "up1_start");
    for (int i = 1; i <= 5; i++)
      applyStimulus(0, 0, 0, 0, 1, 4'd0, 4'(i), (i == 5), 1, 0, $sformatf("up1_%0d", i));
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd5, 0, 0, 1, "up1_done");
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd5, 0, 0, 0, "up1_idle");

    // Down, continuous, mod 3; config inputs wiggle mid-run
    applyStimulus(0, 1, 0, 0, 1, 4'd3, 4'd3, 0, 1, 0, "dnc_start");
    for (int k = 1; k <= 8; k++) begin
      c = 4'(3 - (k % 4));
      applyStimulus(0, 0, 0, 1, 0, 4'($urandom_range(0, 15)), c, (c == 4'd0), 1, 0,
                    $sformatf("dnc_%0d", k));
    end
    applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd3, 0, 0, 0, "dnc_stop");

    // Up, continuous, full range wrap
    applyStimulus(0, 1, 0, 1, 1, 4'd15, 4'd0, 0, 1, 0, "upc_start");
    for (int k = 1; k <= 20; k++) begin
      c = 4'(k % 16);
      applyStimulus(0, 0, 0, 0, 0, 4'd0, c, (c == 4'd15), 1, 0, $sformatf("upc_%0d", k));
    end
    applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd4, 0, 0, 0, "upc_stop");

    // Stop at 2, with mod_val changed to 2 mid-run (must not make tc fire)
    applyStimulus(0, 1, 0, 1, 0, 4'd9, 4'd0, 0, 1, 0, "stop_start");
    applyStimulus(0, 0, 0, 1, 0, 4'd9, 4'd1, 0, 1, 0, "stop_1");
    applyStimulus(0, 0, 0, 1, 0, 4'd2, 4'd2, 0, 1, 0, "stop_2");
    applyStimulus(0, 0, 1, 1, 0, 4'd2, 4'd2, 0, 0, 0, "stop_frozen");
    applyStimulus(0, 0, 0, 1, 0, 4'd2, 4'd2, 0, 0, 0, "stop_idle");

    // mod_val = 0 one-shot, then start during DONE is ignored
    applyStimulus(0, 1, 0, 1, 0, 4'd0, 4'd0, 1, 1, 0, "zero_start");
    applyStimulus(0, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 1, "zero_done");
    applyStimulus(0, 1, 0, 1, 0, 4'd6, 4'd0, 0, 0, 0, "start_in_done");
    applyStimulus(0, 0, 0, 1, 0, 4'd6, 4'd0, 0, 0, 0, "zero_idle");

    // start+stop together in IDLE starts; mod 0 continuous down keeps tc high
    applyStimulus(0, 1, 1, 0, 1, 4'd0, 4'd0, 1, 1, 0, "zc_start");
    applyStimulus(0, 0, 0, 0, 0, 4'd0, 4'd0, 1, 1, 0, "zc_run");
    applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, 0, "zc_stop");

    // Reset mid-run at count 7
    applyStimulus(0, 1, 0, 1, 1, 4'd12, 4'd0, 0, 1, 0, "rst_start");
    for (int i = 1; i <= 7; i++)
      applyStimulus(0, 0, 0, 1, 1, 4'd12, 4'(i), 0, 1, 0, $sformatf("rst_run_%0d", i));
    applyStimulus(1, 1, 0, 1, 1, 4'd12, 4'd0, 0, 0, 0, "rst_mid_run");
    applyStimulus(0, 0, 0, 1, 1, 4'd12, 4'd0, 0, 0, 0, "rst_idle");

    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_leftover: observed %0d entries, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tff_count_ctrl.md
TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, counter width in bits (legal 2..16).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  begin a count sequence (sampled in IDLE only).
REQ-005 SHALL have port: stop  input  1  abort the running sequence.
REQ-006 SHALL have port: up_dn  input  1  direction, 1 = up, 0 = down (captured at start).
REQ-007 SHALL have port: cont  input  1  1 = continuous wrap, 0 = one-shot (captured at start).
REQ-008 SHALL have port: mod_val  input  WIDTH  terminal value (captured at start).
REQ-009 SHALL have port: count  output  WIDTH  current count, direct Q outputs of the toggle-flop bank.
REQ-010 SHALL have port: tc  output  1  terminal-count flag.
REQ-011 SHALL have port: busy  output  1  high in RUN.
REQ-012 SHALL have port: done  output  1  one-cycle one-shot completion pulse.

Function
REQ-013 SHALL hold count in WIDTH toggle flip-flops, each updated only by its per-bit toggle enable T[i] (Q <= Q ^ T[i]); all T[i] = 0 when the count does not change.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: start = 1 at edge k SHALL capture up_dn, cont and mod_val, load count (0 if up, mod_val if down) via toggle enables T = count ^ init, and enter RUN after edge k.
REQ-016 RUN, non-terminal: each edge SHALL advance count by 1 (up: T[i] = AND of count[i-1:0], T[0] = 1) or decrement by 1 (down: T[i] = AND of ~count[i-1:0], T[0] = 1).
REQ-017 Terminal = (count == captured mod_val) when up, (count == 0) when down; tc SHALL equal (state == RUN) AND terminal, combinational from registers.
REQ-018 RUN at terminal with cont = 1: next edge SHALL wrap count (up: T = count, giving 0; down: T = captured mod_val, giving mod_val), state stays RUN; sequence period = mod_val + 1 cycles.
REQ-019 RUN at terminal with cont = 0: count SHALL hold (T = 0); next state DONE.
REQ-020 DONE: done = 1 for exactly one cycle; count holds; next state IDLE.
REQ-021 stop = 1 in RUN SHALL freeze count (T = 0) and return to IDLE at the next edge with no done pulse; stop takes priority over terminal handling.
REQ-022 start outside IDLE and stop outside RUN SHALL be ignored; start and stop asserted together in IDLE SHALL start.
REQ-023 Changes to up_dn, cont or mod_val outside the IDLE start cycle SHALL have no effect.
REQ-024 mod_val = 0 SHALL be legal: terminal on the first RUN cycle; cont = 1 gives tc = 1 every RUN cycle with count = 0.
REQ-025 busy = 1 exactly in RUN; count SHALL hold its value in IDLE and DONE.

Reset
REQ-026 rst SHALL take priority over all inputs, and after the reset edge SHALL leave state = IDLE, count = 0, tc = 0, busy = 0, done = 0, and captured configuration cleared to 0.
REQ-027 rst asserted mid-RUN or in DONE SHALL abort without a done pulse.

Structure
REQ-028 Shared package tff_pkg SHALL hold the FSM state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) and default WIDTH constant.
REQ-029 SHALL instantiate WIDTH copies of sub-module tff_cell (ports clk, rst, t, q: synchronous clear, toggle on t); controller logic only generates t.

Verification (WIDTH = 4)
REQ-030 Up, one-shot: mod_val = 5, start one cycle -> count 0,1,2,3,4,5, tc high with count = 5, done pulse next cycle, then IDLE with count = 5.
REQ-031 Down, continuous: mod_val = 3 -> count 3,2,1,0,3,2..., tc high at each 0, busy steady high.
REQ-032 Up, continuous, mod_val = 15 -> full wrap 15 -> 0, tc every 16 cycles, never done.
REQ-033 stop at count = 2 (up, mod_val = 9) -> count freezes at 2, IDLE next cycle, no done; mod_val changed mid-run -> no effect.
REQ-034 mod_val = 0, one-shot -> tc on the first RUN cycle, done the following cycle.
REQ-035 rst mid-RUN at count = 7 -> count = 0, IDLE, all outputs 0 after the reset edge; start during DONE -> ignored.
